// File: rtl/vmicro16_bus_pkg.sv
// rtl/vmicro16_bus_pkg.sv - shared types and helpers for the vmicro16 bus arbiter
package vmicro16_bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vmicro16_bus_arbiter_if.sv
// rtl/vmicro16_bus_arbiter_if.sv - core-side and slave-side bus signals of the arbiter
interface vmicro16_bus_arbiter_if
    import vmicro16_bus_pkg::*;
#(
    parameter int CORES  = 4,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    localparam int IDW = clog2(CORES);

    logic [CORES-1:0]        m_req;
    logic [CORES-1:0]        m_we;
    logic [CORES*ADDR_W-1:0] m_addr;
    logic [CORES*DATA_W-1:0] m_wdata;
    logic [CORES-1:0]        m_ack;
    logic [CORES-1:0]        m_err;
    logic [DATA_W-1:0]       m_rdata;

    logic                    s_req;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic                    s_ack;
    logic [DATA_W-1:0]       s_rdata;

    logic [IDW-1:0]          grant_id;
    logic                    busy;

    // Requesting side: the cores plus the shared slave.
    modport master (
        output m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, grant_id, busy
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
        output m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, grant_id, busy
    );

endinterface

// File: rtl/vmicro16_rr_pick.sv
// rtl/vmicro16_rr_pick.sv - round-robin winner select: rotate, priority-encode, un-rotate
module vmicro16_rr_pick #(
    parameter int CORES = 4,
    parameter int IDW   = 2
) (
    input  logic [CORES-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   winner,
    output logic             valid
);

    int                 start_idx;
    int                 hit;
    int                 idx;
    logic [2*CORES-1:0] both;
    logic [CORES-1:0]   rot;

    always_comb begin
        start_idx = (int'(last) + 1 >= CORES) ? 0 : int'(last) + 1;
        // rot[j] is the request of core (start_idx + j) mod CORES
        both      = {req, req} >> start_idx;
        rot       = both[CORES-1:0];
        hit       = 0;
        valid     = 1'b0;
        for (int j = CORES - 1; j >= 0; j--) begin
            if (rot[j]) begin
                hit   = j;
                valid = 1'b1;
            end
        end
        idx = start_idx + hit;
        if (idx >= CORES) idx = idx - CORES;
        winner = IDW'(idx);
    end

endmodule

// File: rtl/vmicro16_bus_arbiter.sv
// rtl/vmicro16_bus_arbiter.sv - round-robin arbiter sharing one slave bus between cores
module vmicro16_bus_arbiter
    import vmicro16_bus_pkg::*;
#(
    parameter int CORES   = 4,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    vmicro16_bus_arbiter_if.slave bus
);

    localparam int IDW = clog2(CORES);

    arb_state_t     state;
    logic [IDW-1:0] last;
    logic [7:0]     cnt;
    logic [IDW-1:0] pick;
    logic           pick_valid;

    vmicro16_rr_pick #(
        .CORES (CORES),
        .IDW   (IDW)
    ) u_pick (
        .req    (bus.m_req),
        .last   (last),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            last         <= IDW'(CORES - 1);
            cnt          <= 8'd0;
            bus.s_req    <= 1'b0;
            bus.s_we     <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wdata  <= '0;
            bus.m_ack    <= '0;
            bus.m_err    <= '0;
            bus.m_rdata  <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        bus.s_we     <= bus.m_we[pick];
                        bus.s_addr   <= bus.m_addr[pick*ADDR_W +: ADDR_W];
                        bus.s_wdata  <= bus.m_wdata[pick*DATA_W +: DATA_W];
                        bus.grant_id <= pick;
                        last         <= pick;
                        bus.s_req    <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    cnt <= cnt + 8'd1;
                    // cnt counts completed BUSY cycles, so s_req stays up exactly TIMEOUT cycles
                    if (bus.s_ack) begin
                        bus.m_rdata <= bus.s_rdata;
                        bus.s_req   <= 1'b0;
                        bus.m_ack   <= CORES'(1) << bus.grant_id;
                        state       <= ARB_RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        bus.s_req   <= 1'b0;
                        bus.m_ack   <= CORES'(1) << bus.grant_id;
                        bus.m_err   <= CORES'(1) << bus.grant_id;
                        state       <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    bus.m_ack <= '0;
                    bus.m_err <= '0;
                    cnt       <= 8'd0;
                    bus.busy  <= 1'b0;
                    state     <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vmicro16_bus_arbiter.md
Name: vmicro16_bus_arbiter

Overview:
Shares one slave memory/peripheral bus between CORES vmicro16_cpu instances in a multi-core build.
- Round-robin arbitration, one outstanding transaction at a time.
- Grant is held from issue until slave ack or timeout.
- Slave read data is routed back only to the granted core, with a per-core ack/err pulse.
- Sits between the cores' data-memory ports and the shared bus decoder.

Parameters:
CORES, 4, number of requesting cores (2..8)
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 255, max cycles in BUSY before forced error completion (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
m_req  in  CORES  per-core request; held until m_ack
m_we  in  CORES  per-core write enable
m_addr  in  CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
m_wdata  in  CORES*DATA_W  per-core write data
m_ack  out  CORES  one-cycle completion pulse to the granted core
m_err  out  CORES  one-cycle timeout pulse, coincident with m_ack
m_rdata  out  DATA_W  read data, valid while m_ack is high
s_req  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_ack  in  1  slave completion (single cycle)
s_rdata  in  DATA_W  slave read data, valid with s_ack
grant_id  out  clog2(CORES)  current/last granted core index
busy  out  1  high in BUSY and RESP

Behaviour:
- Reset (reset=0, async): state=IDLE and all outputs 0.
  - last pointer = CORES-1, so core 0 has first priority.
  - timeout counter = 0.
- State IDLE:
  - If any m_req is set, choose the winner: the first set bit scanning from last+1 upward, wrapping.
  - Register winner, we, addr and wdata into s_* and set grant_id=winner and last=winner.
  - Set s_req=1 and go to BUSY. Issue latency is 1 cycle.
- State BUSY:
  - s_* outputs hold their registered values.
  - Counter increments each cycle.
  - On s_ack=1: latch s_rdata into m_rdata (writes latch it too, and it is don't-care for them). Drop s_req, go to RESP.
  - Else, if counter==TIMEOUT: drop s_req, set an err flag, go to RESP.
  - s_ack takes priority over timeout in the same cycle.
- State RESP:
  - m_ack[grant_id]=1 for exactly one cycle, and m_err[grant_id]=err flag.
  - Clear the counter and err flag, return to IDLE.
  - All other m_ack/m_err bits stay 0.
- Minimum turnaround: request seen in IDLE at cycle 0 → s_req at 1 → s_ack at k → m_ack at k+1 → IDLE at k+2.
  - Back-to-back grants are therefore spaced ≥3 cycles apart.
- Requester rules:
  - Hold m_req and its fields stable until m_ack.
  - Deassert m_req the cycle after m_ack, unless issuing a new request.
- m_req dropped during BUSY: the transaction still completes and the ack is issued anyway. No abort.
- s_ack while IDLE or RESP: ignored.
- Fairness: a core that was just granted has lowest priority next arbitration. With all cores requesting, grants rotate 0,1,2,3,0…
- Only one-hot m_ack is legal. Two acks in one cycle is a bug; the bench asserts against it.
- grant_id keeps its last value in IDLE. busy=0 in IDLE.

Decomposition:
- Shared package/header vmicro16_bus_pkg:
  - State encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2.
  - Default ADDR_W and DATA_W.
  - A clog2 function.
- Sub-module vmicro16_rr_pick (combinational):
  - Inputs: req vector and last index.
  - Outputs: winner index and valid.
  - Implemented as a rotate, priority-encode, un-rotate.
  - Unit-testable on its own.

Test Plan:
1. Single read: core 2 requests addr 0x0040 with we=0; slave acks 3 cycles after s_req with s_rdata=0xBEEF → s_addr=0x0040 one cycle after request; m_ack[2]=1 with m_rdata=0xBEEF, m_err=0; no other ack bits set.
2. Round-robin: all 4 cores hold m_req, slave acks immediately each time → grant_id sequence 0,1,2,3,0; s_addr matches each core's address (0x1000+i).
3. Timeout: TIMEOUT=8, core 1 writes 0x1234 to 0x00FF, slave never acks → s_req high for exactly 8 BUSY cycles then drops; m_ack[1]=m_err[1]=1 for one cycle; next request is served normally.
4. Ack/timeout collision: s_ack arrives on the same cycle counter==TIMEOUT → m_err=0, m_rdata=s_rdata.
5. Async reset mid-BUSY: assert reset=0 between clock edges while core 3 is granted → s_req, busy, m_ack and grant_id go to 0 immediately. After release, with cores 1 and 3 requesting, core 1 wins first.
6. Dropped request: core 0 deasserts m_req during BUSY → slave transaction still finishes; m_ack[0] pulses once; no re-grant to core 0.
